instruction_mem: RTL and testbench
==================================

// Module: instruction_mem
// PURPOSE
//  32-word x 32-bit instruction memory for the single-cycle MIPS datapath.
//  Driven by the PC word index; returns the instruction at that word.
//  Holds a built-in default program that is restored on every reset.
//  A load port lets a bench or boot loader overwrite words at run time.
// PARAMETERS
//  DATA_WIDTH  32  instruction word width (fixed; other values unsupported)
//  ADDR_WIDTH  5   word-address width; depth = 2**ADDR_WIDTH = 32 words
// PORTS
//  clk          in   1   single clock, all state updates on rising edge
//  rst_n        in   1   reset, synchronous, active-low
//  addr         in   5   read word address (word index, not byte address)
//  instruction  out  32  instruction word stored at addr
//  load_en      in   1   write strobe for the load port
//  load_addr    in   5   word address to write
//  load_data    in   32  word to write
// BEHAVIOUR
//  - Storage: 32-entry array mem[0..31] of 32-bit words.
//  - Reset: clk rising edge with rst_n=0 reloads ALL 32 words with the default
//    program below; the load port is ignored in that cycle (reset wins).
//  - Default program (hex): 0:20080005 1:2009000A 2:01095020 3:01285822
//    4:AC0A0004 5:8C0C0004 6:114C0001 7..30:00000000 31:0800001F (j 31, halt).
//  - Power-up contents before first reset: same default program (initial load).
//  - Read: instruction = mem[addr], combinational, zero latency; follows addr
//    changes with no clock edge required; unaffected by rst_n level.
//  - Write: clk rising edge with rst_n=1 and load_en=1 -> mem[load_addr]=load_data.
//  - Read-during-write, same address: instruction shows old word until the
//    edge, new word immediately after it (no write-through bypass).
//  - Address range: all 5-bit values valid; no out-of-range case, no wrap logic.
//  - No X on instruction for any addr after first reset or initial load.
// CONFIGURATION
//  REG_OUT_EN defined: instruction is registered; on each clk rising edge
//    instruction <= mem[addr] (pre-write contents); latency 1 cycle; on reset
//    edge instruction <= 32'h00000000 (nop), then mem[addr] from next edge.
//  REG_OUT_EN undefined (default): combinational read as above.
// TESTING
//  1. rst_n=0 one edge, then addr=0 -> instruction=20080005; addr=2 -> 01095020.
//  2. addr=23 -> 00000000; addr=31 -> 0800001F; change addr 0->23->31 between
//     edges -> output tracks each value immediately.
//  3. load_en=1, load_addr=23, load_data=DEADBEEF, addr=23: before edge
//     00000000, after edge DEADBEEF; other words unchanged.
//  4. After test 3, rst_n=0 with load_en=1, load_addr=5, load_data=12345678:
//     after edge addr=23 -> 00000000, addr=5 -> 8C0C0004 (reset wins, reloads).
//  5. load_en=0 for 32 edges with random load_addr/load_data: contents unchanged.
//  6. REG_OUT_EN build: addr=1 at edge k -> instruction=2009000A after edge k;
//     reset edge -> instruction=00000000.

Source files
------------

// File: rtl/instruction_mem.sv
// instruction_mem: 32 x 32-bit instruction memory. Reset restores a built-in program, and a load port overwrites words at run time.
// Define REG_OUT_EN to register the read port (1-cycle latency). The default build uses a combinational read.
module instruction_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] instruction,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Word 31 holds "j 31", so the program parks there once it finishes.
    localparam logic [DATA_WIDTH-1:0] DEFAULT_PROG [DEPTH] = '{
        0:       32'h2008_0005,
        1:       32'h2009_000A,
        2:       32'h0109_5020,
        3:       32'h0128_5822,
        4:       32'hAC0A_0004,
        5:       32'h8C0C_0004,
        6:       32'h114C_0001,
        31:      32'h0800_001F,
        default: '0
    };

    // NOTE: this array is reloaded in full on reset because the program must come back after every reset.
    // The declaration initialiser gives the same contents at power-up, before any reset edge.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = DEFAULT_PROG;

    // NOTE: sequential state uses non-blocking assignments only. A read in the same cycle therefore sees the pre-write word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= DEFAULT_PROG;
        end else if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

`ifdef REG_OUT_EN
    logic [DATA_WIDTH-1:0] instr_q = '0;
    logic [DATA_WIDTH-1:0] instr_d;

    // A reset edge clears the output to a nop. The next edge shows mem[addr] again.
    always_comb begin
        instr_d = '0;
        if (rst_n) begin
            instr_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        instr_q <= instr_d;
    end

    assign instruction = instr_q;
`else
    assign instruction = mem_q[addr];
`endif

endmodule

// File: tb/tb_instruction_mem.sv
// Self-checking bench for instruction_mem. It compares against an array model of the memory contents.
// The REG_OUT_EN build runs the registered-output scenario. The default build runs the combinational-read scenarios.
module tb_instruction_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  addr = '0;
    logic [31:0] instruction;
    logic        load_en = 1'b0;
    logic [4:0]  load_addr = '0;
    logic [31:0] load_data = '0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model [32];

    always #5 clk = ~clk;

    instruction_mem dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .instruction (instruction),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data)
    );

    function automatic logic [31:0] spec_default(int i);
        case (i)
            0:       return 32'h20080005;
            1:       return 32'h2009000A;
            2:       return 32'h01095020;
            3:       return 32'h01285822;
            4:       return 32'hAC0A0004;
            5:       return 32'h8C0C0004;
            6:       return 32'h114C0001;
            31:      return 32'h0800001F;
            default: return 32'h00000000;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = spec_default(i);
    endtask

    // One clock edge. The model applies the edge's effect from the inputs driven before it.
    task automatic step();
        logic        r = rst_n;
        logic        we = load_en;
        logic [4:0]  wa = load_addr;
        logic [31:0] wd = load_data;
        @(posedge clk);
        #1;
        if (!r) model_reset();
        else if (we) model[wa] = wd;
    endtask

`ifndef REG_OUT_EN
    task automatic test_powerup();
        addr = 5'd0;
        #1;
        n_cmp++;
        if (instruction !== 32'h20080005) begin
            n_bad++;
            $display("FAIL powerup addr0: got %h want %h", instruction, 32'h20080005);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        addr = 5'd0;
        #1;
        n_cmp++;
        if (instruction !== 32'h20080005) begin
            n_bad++;
            $display("FAIL reset addr0: got %h want %h", instruction, 32'h20080005);
        end
        addr = 5'd2;
        #1;
        n_cmp++;
        if (instruction !== 32'h01095020) begin
            n_bad++;
            $display("FAIL reset addr2: got %h want %h", instruction, 32'h01095020);
        end
    endtask

    // Reads follow addr between clock edges, with no clock edge needed.
    task automatic test_read_sweep(string tag);
        int a;
        for (int i = 0; i < 32; i++) begin
            a = (i * 23) % 32;
            addr = 5'(a);
            #1;
            n_cmp++;
            if (instruction !== model[a]) begin
                n_bad++;
                $display("FAIL %s addr %0d: got %h want %h", tag, a, instruction, model[a]);
            end
        end
    endtask

    task automatic test_load();
        load_en = 1'b1;
        load_addr = 5'd23;
        load_data = 32'hDEADBEEF;
        addr = 5'd23;
        #1;
        n_cmp++;
        if (instruction !== 32'h00000000) begin
            n_bad++;
            $display("FAIL load before edge: got %h want %h", instruction, 32'h0);
        end
        step();
        load_en = 1'b0;
        n_cmp++;
        if (instruction !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL load after edge: got %h want %h", instruction, 32'hDEADBEEF);
        end
        test_read_sweep("load_others");
    endtask

    task automatic test_reset_wins();
        rst_n = 1'b0;
        load_en = 1'b1;
        load_addr = 5'd5;
        load_data = 32'h12345678;
        step();
        rst_n = 1'b1;
        load_en = 1'b0;
        addr = 5'd23;
        #1;
        n_cmp++;
        if (instruction !== 32'h00000000) begin
            n_bad++;
            $display("FAIL reset_wins addr23: got %h want %h", instruction, 32'h0);
        end
        addr = 5'd5;
        #1;
        n_cmp++;
        if (instruction !== 32'h8C0C0004) begin
            n_bad++;
            $display("FAIL reset_wins addr5: got %h want %h", instruction, 32'h8C0C0004);
        end
    endtask

    task automatic test_load_disabled();
        load_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            load_addr = 5'($urandom_range(31));
            load_data = $urandom;
            step();
        end
        test_read_sweep("load_disabled");
    endtask

    // Random loads and reads. Before each edge the old word is visible; after it the new word is.
    task automatic test_random();
        logic [31:0] exp;
        for (int i = 0; i < 300; i++) begin
            load_en = ($urandom_range(1) == 1);
            load_addr = 5'($urandom_range(31));
            load_data = $urandom;
            addr = ($urandom_range(2) == 0) ? load_addr : 5'($urandom_range(31));
            #1;
            exp = model[addr];
            n_cmp++;
            if (instruction !== exp) begin
                n_bad++;
                $display("FAIL random pre-edge it %0d addr %0d: got %h want %h", i, addr, instruction, exp);
            end
            step();
            exp = model[addr];
            n_cmp++;
            if (instruction !== exp) begin
                n_bad++;
                $display("FAIL random post-edge it %0d addr %0d: got %h want %h", i, addr, instruction, exp);
            end
        end
        load_en = 1'b0;
    endtask
`else
    task automatic test_reg_out();
        logic [31:0] exp;
        rst_n = 1'b0;
        addr = 5'd1;
        step();
        n_cmp++;
        if (instruction !== 32'h00000000) begin
            n_bad++;
            $display("FAIL reg reset: got %h want %h", instruction, 32'h0);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (instruction !== 32'h2009000A) begin
            n_bad++;
            $display("FAIL reg addr1: got %h want %h", instruction, 32'h2009000A);
        end
        for (int i = 0; i < 300; i++) begin
            rst_n = ($urandom_range(19) != 0);
            load_en = ($urandom_range(1) == 1);
            load_addr = 5'($urandom_range(31));
            load_data = $urandom;
            addr = ($urandom_range(2) == 0) ? load_addr : 5'($urandom_range(31));
            exp = rst_n ? model[addr] : 32'h0;
            step();
            n_cmp++;
            if (instruction !== exp) begin
                n_bad++;
                $display("FAIL reg random it %0d addr %0d: got %h want %h", i, addr, instruction, exp);
            end
        end
        rst_n = 1'b1;
        load_en = 1'b0;
    endtask
`endif

    initial begin
        model_reset();
`ifndef REG_OUT_EN
        test_powerup();
        test_reset();
        test_read_sweep("default_prog");
        test_load();
        test_reset_wins();
        test_read_sweep("after_reset");
        test_load_disabled();
        test_random();
        test_read_sweep("final");
`else
        test_reg_out();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
